button_debouncer: RTL and testbench

- Front-end conditioning stage for the board push-buttons. Synchronises the raw active-low pad inputs, debounces each one independently, and drives clean active-high levels.
- btn_level connects directly to the 3-bit in_port of the button PIO slave. That slave's edge-capture logic therefore sees exactly one edge per physical press or release.
- Also provides one-cycle press/release strobes for local logic that does not go through the bus.

---
 rtl/button_debouncer_pkg.sv | 23 ++
 rtl/button_debouncer_if.sv | 29 ++
 rtl/button_debounce_chan.sv | 111 +++++++++++
 rtl/button_debouncer.sv | 59 +++++
 tb/tb_button_debouncer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared types and defaults for the push-button conditioning front end.
// Channel FSM states, counter sizing helper and default timing constants.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED      = 2'd0,
    CHECK_PRESS   = 2'd1,
    PRESSED       = 2'd2,
    CHECK_RELEASE = 2'd3
  } chan_state_t;

  // 1 ms sample period at 50 MHz, 20 agreeing samples to accept a level.
  localparam int TICK_DIV_DEF     = 50000;
  localparam int STABLE_TICKS_DEF = 20;

  // Counter must hold 0..stable_ticks; never narrower than one bit.
  function automatic int cnt_width(input int stable_ticks);
    int w;
    w = $clog2(stable_ticks + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button conditioning signal bundle: raw pads in, clean levels/strobes out.
// master drives the pads and observes; slave is the debouncer itself.
interface button_debouncer_if #(
  parameter int N_BTN = 3
);

  logic [N_BTN-1:0] btn_n_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] release_pulse;
  logic             tick;

  modport master (
    output btn_n_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  tick
  );

  modport slave (
    input  btn_n_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output tick
  );

endinterface

// File: rtl/button_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, tick-paced FSM, level and strobes.
//
//   state         | meaning
//   --------------+---------------------------------------------------
//   RELEASED      | accepted level 0, waiting for a pressed sample
//   CHECK_PRESS   | counting agreeing pressed samples, level still 0
//   PRESSED       | accepted level 1, waiting for a released sample
//   CHECK_RELEASE | counting agreeing released samples, level still 1
module button_debounce_chan
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn_n_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int             CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam bit             DIRECT   = (STABLE_TICKS == 1);

  logic [1:0]    sync_q;
  logic          sync_i;
  chan_state_t   state;
  logic [CW-1:0] cnt;

  // Stage 1 takes the inverted pad, so sync_i is already active-high.
  assign sync_i = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= 2'b00;
      state         <= RELEASED;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], ~btn_n_raw};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;

      if (tick) begin
        unique case (state)
          RELEASED: begin
            if (sync_i) begin
              if (DIRECT) begin
                state       <= PRESSED;
                cnt         <= '0;
                btn_level   <= 1'b1;
                press_pulse <= 1'b1;
              end else begin
                state <= CHECK_PRESS;
                cnt   <= CNT_ONE;
              end
            end
          end

          CHECK_PRESS: begin
            if (!sync_i) begin
              state <= RELEASED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state       <= PRESSED;
              cnt         <= '0;
              btn_level   <= 1'b1;
              press_pulse <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          PRESSED: begin
            if (!sync_i) begin
              if (DIRECT) begin
                state         <= RELEASED;
                cnt           <= '0;
                btn_level     <= 1'b0;
                release_pulse <= 1'b1;
              end else begin
                state <= CHECK_RELEASE;
                cnt   <= CNT_ONE;
              end
            end
          end

          CHECK_RELEASE: begin
            if (sync_i) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state         <= RELEASED;
              cnt           <= '0;
              btn_level     <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button front end: shared sample-tick prescaler plus one debounce
// channel per button; btn_level feeds the button PIO in_port directly.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int N_BTN        = 3,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  button_debouncer_if.slave    bus
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  logic [PW-1:0]    pre_cnt;
  logic             tick_q;
  logic [N_BTN-1:0] level_v;
  logic [N_BTN-1:0] press_v;
  logic [N_BTN-1:0] release_v;

  // tick is high for the cycle after the counter reaches its last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= (pre_cnt == PRE_LAST);
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PRE_ONE;
      end
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_chan (
      .clk           (clk),
      .reset_n       (reset_n),
      .tick          (tick_q),
      .btn_n_raw     (bus.btn_n_raw[i]),
      .btn_level     (level_v[i]),
      .press_pulse   (press_v[i]),
      .release_pulse (release_v[i])
    );
  end

  assign bus.btn_level     = level_v;
  assign bus.press_pulse   = press_v;
  assign bus.release_pulse = release_v;
  assign bus.tick          = tick_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with TICK_DIV=4, STABLE_TICKS=3.
// Outputs are sampled 1 time unit after each rising clk edge.
module tb_button_debouncer;

  logic clk;
  logic reset_n;

  int compared   = 0;
  int mismatched = 0;

  button_debouncer_if #(.N_BTN(3)) bus ();

  button_debouncer #(
    .N_BTN        (3),
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    compared++;
    assert (obs >= lo && obs <= hi)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Step until btn_level[b] reads val (max 40 edges); edges=-1 on timeout.
  task automatic wait_level(input int b, input logic val, output int edges,
                            output logic [2:0] pp, output logic [2:0] rp,
                            output logic [2:0] pp_seen, output logic [2:0] rp_seen);
    edges   = -1;
    pp      = 3'b000;
    rp      = 3'b000;
    pp_seen = 3'b000;
    rp_seen = 3'b000;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      pp_seen |= bus.press_pulse;
      rp_seen |= bus.release_pulse;
      if (bus.btn_level[b] === val) begin
        edges = k;
        pp    = bus.press_pulse;
        rp    = bus.release_pulse;
        break;
      end
    end
  endtask

  initial begin : stim
    int         edges;
    int         n;
    logic [2:0] pp, rp, pp_seen, rp_seen;
    logic       lvl1_seen;

    // Reset with every button held down.
    reset_n       = 1'b0;
    bus.btn_n_raw = 3'b000;
    step(3);
    chk("rst_level",   bus.btn_level,     3'b000);
    chk("rst_press",   bus.press_pulse,   3'b000);
    chk("rst_release", bus.release_pulse, 3'b000);
    chk("rst_tick",    bus.tick,          1'b0);

    reset_n = 1'b1;
    wait_level(0, 1'b1, edges, pp, rp, pp_seen, rp_seen);
    chk_range("rst_accept_latency", edges, 11, 14);
    chk("rst_accept_level", bus.btn_level, 3'b111);
    chk("rst_accept_press", pp, 3'b111);
    step(1);
    chk("rst_accept_press_end", bus.press_pulse, 3'b000);

    bus.btn_n_raw = 3'b111;
    step(30);
    chk("all_released", bus.btn_level, 3'b000);

    // Clean press of bit 0.
    bus.btn_n_raw = 3'b110;
    wait_level(0, 1'b1, edges, pp, rp, pp_seen, rp_seen);
    chk_range("press0_latency", edges, 11, 14);
    chk("press0_level", bus.btn_level, 3'b001);
    chk("press0_pulse", pp, 3'b001);
    step(1);
    chk("press0_pulse_end", bus.press_pulse, 3'b000);

    // Tick period and width.
    n = 0;
    while (bus.tick !== 1'b1 && n < 10) begin
      step(1);
      n++;
    end
    n = 0;
    do begin
      step(1);
      n++;
    end while (bus.tick !== 1'b1 && n < 10);
    chk("tick_period", n, 4);
    step(1);
    chk("tick_width", bus.tick, 1'b0);

    // Bounce on bit 1: 5-clk toggles never span 3 agreeing ticks.
    lvl1_seen = 1'b0;
    pp_seen   = 3'b000;
    rp_seen   = 3'b000;
    for (int i = 0; i < 8; i++) begin
      bus.btn_n_raw[1] = ~bus.btn_n_raw[1];
      for (int j = 0; j < 5; j++) begin
        step(1);
        lvl1_seen |= bus.btn_level[1];
        pp_seen   |= bus.press_pulse;
        rp_seen   |= bus.release_pulse;
      end
    end
    chk("bounce_level",   lvl1_seen, 1'b0);
    chk("bounce_press",   pp_seen,   3'b000);
    chk("bounce_release", rp_seen,   3'b000);

    bus.btn_n_raw[1] = 1'b0;
    wait_level(1, 1'b1, edges, pp, rp, pp_seen, rp_seen);
    chk_range("settle1_latency", edges, 11, 14);
    chk("settle1_level", bus.btn_level, 3'b011);
    chk("settle1_pulse", pp, 3'b010);
    step(1);
    chk("settle1_pulse_end", bus.press_pulse, 3'b000);

    // Release of bit 0.
    bus.btn_n_raw[0] = 1'b1;
    wait_level(0, 1'b0, edges, pp, rp, pp_seen, rp_seen);
    chk_range("release0_latency", edges, 11, 14);
    chk("release0_pulse", rp, 3'b001);
    chk("release0_no_press", pp_seen, 3'b000);
    chk("release0_level", bus.btn_level, 3'b010);
    step(1);
    chk("release0_pulse_end", bus.release_pulse, 3'b000);

    bus.btn_n_raw = 3'b111;
    step(30);
    chk("all_released2", bus.btn_level, 3'b000);

    // Bits 0 and 2 pressed on the same clock.
    bus.btn_n_raw = 3'b010;
    wait_level(0, 1'b1, edges, pp, rp, pp_seen, rp_seen);
    chk_range("simul_latency", edges, 11, 14);
    chk("simul_level", bus.btn_level, 3'b101);
    chk("simul_pulse", pp, 3'b101);

    bus.btn_n_raw = 3'b111;
    step(30);
    chk("all_released3", bus.btn_level, 3'b000);

    // Reset while bit 2 is mid-debounce.
    bus.btn_n_raw = 3'b011;
    step(8);
    chk("mid_pre_level", bus.btn_level, 3'b000);
    reset_n = 1'b0;
    step(3);
    chk("mid_rst_level",   bus.btn_level,     3'b000);
    chk("mid_rst_press",   bus.press_pulse,   3'b000);
    chk("mid_rst_release", bus.release_pulse, 3'b000);
    reset_n = 1'b1;
    wait_level(2, 1'b1, edges, pp, rp, pp_seen, rp_seen);
    chk_range("mid_accept_latency", edges, 11, 14);
    chk("mid_accept_level", bus.btn_level, 3'b100);
    chk("mid_accept_pulse", pp, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
